lane_sequencer: RTL and testbench
=================================

LANE_SEQUENCER -- requirements
Module: lane_sequencer

Interface
REQ-001 Parameter LANE_LEN, default 32: number of note slots in one lane pattern.
REQ-002 Parameter TICK_BASE, default 50000000: clk cycles per lane shift at speed 0.
REQ-003 Parameter SCORE_MAX, default 20: score saturation ceiling, matches the two-digit score display.
REQ-004 clk  input  1  system clock, 50 MHz; all state changes on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-high reset; the name is kept for codebase consistency even though the polarity is high.
REQ-006 running  input  1  run/pause level (switch).
REQ-007 speed  input  2  shift-rate select.
REQ-008 press  input  1  lane button, active-high level, already synchronised.
REQ-009 pattern  input  LANE_LEN  note map; bit 0 reaches the hit line first.
REQ-010 lane  output  LANE_LEN  current lane contents; bit 0 is the hit slot.
REQ-011 score  output  5  current score, 0..SCORE_MAX.
REQ-012 state  output  2  FSM state code: 0 IDLE, 1 PLAY, 2 PAUSE, 3 DONE.
REQ-013 tick  output  1  one-cycle pulse on each lane shift.
REQ-014 hit  output  1  one-cycle pulse on each scored hit.
REQ-015 miss  output  1  one-cycle pulse on each scored miss.

Function
REQ-016 Tick period SHALL be TICK_BASE cycles at speed 0, TICK_BASE/2 at speed 1, TICK_BASE/4 at speed 2 and TICK_BASE/8 at speed 3, using integer division.
REQ-017 The tick counter SHALL count only in PLAY, hold its value in PAUSE, and clear in IDLE and DONE.
REQ-018 tick SHALL assert for one cycle when the counter reaches period-1; the counter then wraps to 0.
REQ-019 A speed change SHALL take effect from the next wrap; if the counter already exceeds the new period-1, it SHALL wrap on the next cycle.
REQ-020 In IDLE: lane SHALL equal pattern, and score, shift count and the pressed flag SHALL be held at 0.
REQ-021 IDLE -> PLAY SHALL occur on the first cycle with running=1.
REQ-022 PLAY -> PAUSE SHALL occur when running=0.
REQ-023 PAUSE -> PLAY SHALL occur when running=1; lane, score and counter are preserved across the pause.
REQ-024 On each tick in PLAY: lane SHALL shift right by 1 with 0 entering the MSB, and the shift count SHALL increment.
REQ-025 PLAY -> DONE SHALL occur on the tick that brings the shift count to LANE_LEN.
REQ-026 DONE -> IDLE SHALL occur when running=0.
REQ-027 In DONE, lane and score SHALL hold, and press SHALL be ignored.
REQ-028 A press event is a 0->1 transition of press, detected from a registered copy of press; holding press down SHALL yield only one event.
REQ-029 The scoring interval is the span between consecutive ticks; at most one press SHALL be scored per interval, tracked by a pressed flag that clears on each tick.
REQ-030 A press event in PLAY with pressed=0 and lane[0]=1 SHALL pulse hit and set score to min(score+1, SCORE_MAX).
REQ-031 A press event in PLAY with pressed=0 and lane[0]=0 SHALL pulse miss and set score to max(score-1, 0).
REQ-032 On a tick with pressed=0 and lane[0]=1 (note passed unplayed), the block SHALL pulse miss and decrement score, saturating at 0.
REQ-033 If a press event and a tick occur in the same cycle, the press SHALL be scored against the pre-shift lane[0] and the unplayed-note miss SHALL be suppressed; at most one of hit/miss pulses per cycle.
REQ-034 Press events in PAUSE and IDLE SHALL be ignored and SHALL NOT set the pressed flag.
REQ-035 hit, miss and tick SHALL be registered outputs, each one cycle wide.

Reset
REQ-036 While resetn=1, asynchronously: state=IDLE, lane=0, score=0, tick=hit=miss=0, and counter, shift count, pressed flag and registered press SHALL all be 0.
REQ-037 After resetn falls, lane SHALL load pattern on the first clk edge.
REQ-038 Assertion of resetn in any state, including mid-tick or mid-press, SHALL abort the game with no pulse emitted.

Verification (TICK_BASE=8, LANE_LEN=8)
REQ-039 pattern=8'b0000_0101, speed=0, running=1, press on cycles 3 and 19 -> hit at 3, hit at 19, score=2; tick every 8 cycles.
REQ-040 pattern=8'h01, no press -> first tick pulses miss, score stays 0 (saturation), lane=8'h00.
REQ-041 score=20, further hit -> hit pulses, score remains 20.
REQ-042 speed=3 -> tick every cycle; after 8 ticks state=DONE; running=0 -> IDLE with lane=pattern.
REQ-043 running dropped at counter=5 for 20 cycles, then raised -> next tick 3 cycles later; press during the pause yields no pulse.
REQ-044 press rising in the same cycle as a tick with lane[0]=1 -> single hit, no miss; resetn pulse in PLAY -> all outputs 0 immediately.

Source files
------------

// File: rtl/lane_sequencer.sv
// Rhythm-game lane sequencer: shifts a note pattern toward the hit slot at a
// selectable rate and scores button presses against the note in the hit slot.
module lane_sequencer #(
   parameter int LANE_LEN  = 32,
   parameter int TICK_BASE = 50000000,
   parameter int SCORE_MAX = 20
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                running,
   input  logic [1:0]          speed,
   input  logic                press,
   input  logic [LANE_LEN-1:0] pattern,
   output logic [LANE_LEN-1:0] lane,
   output logic [4:0]          score,
   output logic [1:0]          state,
   output logic                tick,
   output logic                hit,
   output logic                miss
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PLAY  = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int CW = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;
   localparam int SW = $clog2(LANE_LEN + 1);

   // Terminal counts per speed; periods that divide down to 0 or 1 tick every cycle.
   localparam int L0 = (TICK_BASE     > 1) ? TICK_BASE     - 1 : 0;
   localparam int L1 = (TICK_BASE / 2 > 1) ? TICK_BASE / 2 - 1 : 0;
   localparam int L2 = (TICK_BASE / 4 > 1) ? TICK_BASE / 4 - 1 : 0;
   localparam int L3 = (TICK_BASE / 8 > 1) ? TICK_BASE / 8 - 1 : 0;

   localparam logic [4:0]    SCORE_TOP = 5'(SCORE_MAX);
   localparam logic [SW-1:0] LAST_SHIFT = SW'(LANE_LEN - 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] period_m1;
   logic [SW-1:0] shift_cnt;
   logic          pressed;
   logic          press_q;
   logic          press_evt;
   logic          tick_due;

   always_comb begin
      period_m1 = CW'(L0);
      case (speed)
         2'd0:    period_m1 = CW'(L0);
         2'd1:    period_m1 = CW'(L1);
         2'd2:    period_m1 = CW'(L2);
         default: period_m1 = CW'(L3);
      endcase
   end

   // Using >= lets a speed-up past the current count wrap on the next cycle.
   assign tick_due  = (cnt >= period_m1);
   assign press_evt = press & ~press_q;

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         state     <= S_IDLE;
         lane      <= '0;
         score     <= '0;
         tick      <= 1'b0;
         hit       <= 1'b0;
         miss      <= 1'b0;
         cnt       <= '0;
         shift_cnt <= '0;
         pressed   <= 1'b0;
         press_q   <= 1'b0;
      end else begin
         press_q <= press;
         tick    <= 1'b0;
         hit     <= 1'b0;
         miss    <= 1'b0;
         case (state)
            S_IDLE: begin
               lane      <= pattern;
               score     <= '0;
               shift_cnt <= '0;
               pressed   <= 1'b0;
               cnt       <= '0;
               if (running) state <= S_PLAY;
            end
            S_PLAY: begin
               // The cycle that sees running low only moves to PAUSE, so the
               // counter freezes at the value it held when the switch dropped.
               if (!running) begin
                  state <= S_PAUSE;
               end else begin
                  if (tick_due) begin
                     cnt       <= '0;
                     tick      <= 1'b1;
                     lane      <= {1'b0, lane[LANE_LEN-1:1]};
                     shift_cnt <= shift_cnt + 1'b1;
                     pressed   <= 1'b0;
                     if (shift_cnt == LAST_SHIFT) state <= S_DONE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
                  // A press is judged on the pre-shift hit slot and pre-empts the unplayed-note miss.
                  if (press_evt && !pressed) begin
                     if (!tick_due) pressed <= 1'b1;
                     if (lane[0]) begin
                        hit <= 1'b1;
                        if (score < SCORE_TOP) score <= score + 1'b1;
                     end else begin
                        miss <= 1'b1;
                        if (score != 5'd0) score <= score - 1'b1;
                     end
                  end else if (tick_due && !pressed && lane[0]) begin
                     miss <= 1'b1;
                     if (score != 5'd0) score <= score - 1'b1;
                  end
               end
            end
            S_PAUSE: begin
               if (running) state <= S_PLAY;
            end
            default: begin
               cnt <= '0;
               if (!running) begin
                  state     <= S_IDLE;
                  lane      <= pattern;
                  score     <= '0;
                  shift_cnt <= '0;
                  pressed   <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lane_sequencer.sv
// Directed bench for lane_sequencer: an 8-slot lane for timing, scoring, pause,
// speed and reset cases, plus a 32-slot lane for score saturation.
module tb_lane_sequencer;

   logic       clk;
   logic       resetn;
   logic       running, press;
   logic [1:0] speed;
   logic [7:0] pattern, lane;
   logic [4:0] score;
   logic [1:0] state;
   logic       tick, hit, miss;

   logic        running2, press2;
   logic [31:0] pattern2, lane2;
   logic [4:0]  score2;
   logic [1:0]  state2;
   logic        tick2, hit2, miss2;

   int n_checks = 0;
   int n_bad    = 0;
   logic [7:0] exp_q[$];

   lane_sequencer #(.LANE_LEN(8), .TICK_BASE(8), .SCORE_MAX(20)) dut (
      .clk(clk), .resetn(resetn), .running(running), .speed(speed), .press(press),
      .pattern(pattern), .lane(lane), .score(score), .state(state),
      .tick(tick), .hit(hit), .miss(miss)
   );

   lane_sequencer #(.LANE_LEN(32), .TICK_BASE(8), .SCORE_MAX(20)) dut_sat (
      .clk(clk), .resetn(resetn), .running(running2), .speed(2'd2), .press(press2),
      .pattern(pattern2), .lane(lane2), .score(score2), .state(state2),
      .tick(tick2), .hit(hit2), .miss(miss2)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "bench timeout");
   end

   // driver tasks
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial begin
      logic pulse_seen;
      logic sat_done, at_max, over_max;
      logic [4:0] prev_score;
      int hits, misses;

      resetn = 1'b1; running = 1'b0; press = 1'b0; speed = 2'd0; pattern = 8'h05;
      running2 = 1'b0; press2 = 1'b0; pattern2 = 32'hFFFF_FFFF;
      #12;
      check_eq("rst_state", state, 0);
      check_eq("rst_lane", lane, 0);
      check_eq("rst_score", score, 0);
      check_eq("rst_pulses", {tick, hit, miss}, 0);
      @(negedge clk) resetn = 1'b0;
      step(1);
      check_eq("idle_lane_load", lane, 8'h05);
      check_eq("idle_state", state, 0);

      // two hits at cycles 3 and 19, tick every 8
      exp_q.push_back(8'h02); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
      running = 1'b1;
      step(1);
      check_eq("play_entry", state, 1);
      step(2); press = 1'b1;
      step(1);
      check_eq("hit_c3", hit, 1);
      check_eq("score_c3", score, 1);
      check_eq("no_miss_c3", miss, 0);
      press = 1'b0;
      step(1);
      check_eq("hit_one_cycle", hit, 0);
      step(3);
      check_eq("no_tick_c7", tick, 0);
      step(1);
      check_eq("tick_c8", tick, 1);
      check_eq("lane_c8", lane, exp_q.pop_front());
      check_eq("no_miss_c8", miss, 0);
      step(8);
      check_eq("tick_c16", tick, 1);
      check_eq("lane_c16", lane, exp_q.pop_front());
      step(2); press = 1'b1;
      step(1);
      check_eq("hit_c19", hit, 1);
      check_eq("score_c19", score, 2);
      press = 1'b0;
      step(5);
      check_eq("tick_c24", tick, 1);
      check_eq("lane_c24", lane, exp_q.pop_front());
      check_eq("no_miss_c24", miss, 0);
      step(39);
      check_eq("play_c63", state, 1);
      step(1);
      check_eq("done_c64", state, 3);
      check_eq("done_score", score, 2);
      press = 1'b1;
      step(1);
      check_eq("done_press_ignored", {hit, miss}, 0);
      check_eq("done_score_hold", score, 2);
      press = 1'b0; running = 1'b0;
      step(1);
      check_eq("done_to_idle", state, 0);
      check_eq("idle_lane_reload", lane, 8'h05);
      check_eq("idle_score_clear", score, 0);

      // unplayed note at 0 score, then pause with counter at 5
      pattern = 8'h01;
      step(1);
      check_eq("idle_lane_01", lane, 8'h01);
      running = 1'b1;
      step(1);
      step(8);
      check_eq("unplayed_tick", tick, 1);
      check_eq("unplayed_miss", miss, 1);
      check_eq("unplayed_score_sat", score, 0);
      check_eq("unplayed_lane", lane, 8'h00);
      step(5);
      running = 1'b0;
      step(1);
      check_eq("pause_entry", state, 2);
      pulse_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) press = 1'b1;
         if (i == 12) press = 1'b0;
         step(1);
         pulse_seen = pulse_seen | hit | miss | tick;
      end
      check_eq("pause_no_pulse", pulse_seen, 0);
      check_eq("pause_held", state, 2);
      running = 1'b1;
      step(1);
      check_eq("resume_state", state, 1);
      press = 1'b1;
      step(1);
      check_eq("resume_press_miss", miss, 1);
      press = 1'b0;
      step(1);
      check_eq("resume_no_tick_2", tick, 0);
      step(1);
      check_eq("resume_tick_3", tick, 1);
      resetn = 1'b1;
      #1;
      check_eq("async_rst_tick", tick, 0);
      check_eq("async_rst_state", state, 0);
      check_eq("async_rst_lane", lane, 0);
      running = 1'b0;
      @(negedge clk) resetn = 1'b0;

      // press on the tick edge, then an unplayed note, then speed 3 to the end
      pattern = 8'h03;
      step(1);
      check_eq("idle_lane_03", lane, 8'h03);
      running = 1'b1;
      step(1);
      step(7); press = 1'b1;
      step(1);
      check_eq("same_cycle_tick", tick, 1);
      check_eq("same_cycle_hit", hit, 1);
      check_eq("same_cycle_no_miss", miss, 0);
      check_eq("same_cycle_score", score, 1);
      check_eq("same_cycle_lane", lane, 8'h01);
      press = 1'b0;
      step(8);
      check_eq("pass_miss", miss, 1);
      check_eq("pass_no_hit", hit, 0);
      check_eq("pass_score", score, 0);
      step(4); speed = 2'd3;
      step(1);
      check_eq("fast_wrap_now", tick, 1);
      step(1);
      check_eq("fast_tick_each", tick, 1);
      step(3);
      check_eq("fast_still_play", state, 1);
      step(1);
      check_eq("fast_done", state, 3);
      step(1);
      check_eq("done_no_tick", tick, 0);
      running = 1'b0;
      step(1);
      check_eq("fast_idle", state, 0);
      check_eq("fast_idle_lane", lane, 8'h03);
      speed = 2'd0;

      // saturation on a 32-slot all-notes lane, one press per interval
      hits = 0; misses = 0; sat_done = 1'b0; at_max = 1'b0; over_max = 1'b0;
      running2 = 1'b1; press2 = 1'b1;
      step(1);
      prev_score = score2;
      for (int i = 0; i < 100 && !sat_done; i++) begin
         press2 = ~press2;
         step(1);
         if (hit2) begin
            hits++;
            if (prev_score == 5'd20 && score2 == 5'd20) at_max = 1'b1;
         end
         if (miss2) misses++;
         if (score2 > 5'd20) over_max = 1'b1;
         prev_score = score2;
         if (state2 == 2'd3) sat_done = 1'b1;
      end
      check_eq("sat_reached_done", sat_done, 1);
      check_eq("sat_hits", hits, 32);
      check_eq("sat_misses", misses, 0);
      check_eq("sat_score", score2, 20);
      check_eq("sat_hit_at_max", at_max, 1);
      check_eq("sat_never_over", over_max, 0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
